// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// The state enum includes ST_CHECK. That state is only reachable when the
// loader is built with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    // Width of one LEGv8 instruction word.
    localparam int INSTR_W = 32;

    // Default instruction-memory word-address width (256 words).
    localparam int DEFAULT_ADDR_W = 8;

    // Default number of cycles the core stays in reset after the last write.
    localparam int DEFAULT_HOLD_CYCLES = 4;

    // Loader phases. ST_CHECK waits for the trailing checksum word.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } imem_loader_state_t;

endpackage

// File: rtl/imem_loader_xsum.sv
// imem_loader_xsum: running XOR of the accepted program words.
// It is used only by imem_loader builds with IMEM_LOADER_CHECKSUM_EN.
// clear takes priority over accumulate, so a new load always starts from zero.
module imem_loader_xsum
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               accumulate,
    input  logic [INSTR_W-1:0] data,
    input  logic [INSTR_W-1:0] check_data,
    output logic               match
);

    logic [INSTR_W-1:0] sum_q;

    // Accumulator: XOR in every accepted program word; clear on a new load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (accumulate) begin
            sum_q <= sum_q ^ data;
        end
    end

    // Compare the incoming checksum word against the XOR accumulated so far.
    always_comb begin
        match = (sum_q == check_data);
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the LEGv8 instruction memory.
// Program words arrive on a valid/ready stream. They are written to word
// addresses 0, 1, 2, ... The core's PC is held in reset until HOLD_CYCLES+1
// cycles after the last write.
// Build option: define IMEM_LOADER_CHECKSUM_EN to require one trailing XOR
// checksum word after the s_last word. That word is checked and is not written.
//
// Stream handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready is decoded from the registered state only, so it never depends on
// s_valid in the same cycle. While s_valid is high and s_ready is low, the
// source must hold s_data and s_last stable.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               s_valid,
    input  logic [INSTR_W-1:0] s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_reset,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    word_count,
    output imem_loader_state_t dbg_state
);

    // The hold counter runs 0..HOLD_CYCLES. The extra cycle covers the write pulse.
    localparam int                HOLD_W    = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

    imem_loader_state_t state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               start_load;
    logic               load_accept;

    // start is honoured only when no load or hold is in progress.
    assign start_load  = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                                   (state_q == ST_ERR));
    // A program word is taken whenever LOAD sees s_valid.
    assign load_accept = (state_q == ST_LOAD) && s_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic xsum_match;

    imem_loader_xsum u_xsum (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_load),
        .accumulate (load_accept),
        .data       (s_data),
        .check_data (s_data),
        .match      (xsum_match)
    );

    assign s_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
    assign s_ready = (state_q == ST_LOAD);
`endif

    // State, address, word count and hold counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic for the load sequence: load, optional check, hold, then run or error.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start_load) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_accept) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
                    if (s_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_HOLD;
`endif
                        hold_d  = '0;
                    end else if (addr_q == ADDR_MAX) begin
                        // The last word has been written. Do not wrap back onto address 0.
                        state_d = ST_ERR;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (s_valid) begin
                    state_d = xsum_match ? ST_HOLD : ST_ERR;
                    hold_d  = '0;
                end
            end
`endif
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write port: issue one registered write pulse for each accepted program word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= load_accept;
            if (load_accept) begin
                waddr_q <= addr_q;
                wdata_q <= s_data;
            end
        end
    end

    // Status outputs are decoded from the registered state. When start leaves
    // RUN, core_reset rises in the same cycle that the state changes.
    always_comb begin
        core_reset = (state_q != ST_RUN);
        done       = (state_q == ST_RUN);
        error      = (state_q == ST_ERR);
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign dbg_state  = state_q;

endmodule
